// File: rtl/bit_adder_unit.sv
// Single-bit adder with optional output register and a saturating carry-event counter.
// Sum and carry are combinational by default; carry_cnt counts clock edges with a&b set.
module bit_adder_unit #(
    parameter bit          REG_OUT = 1'b0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             co,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sum;
    logic carry;

    assign sum   = a ^ b;
    assign carry = a & b;

    generate
        if (REG_OUT) begin : g_reg
            logic c_q;
            logic co_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    c_q  <= 1'b0;
                    co_q <= 1'b0;
                end else begin
                    c_q  <= sum;
                    co_q <= carry;
                end
            end

            assign c  = c_q;
            assign co = co_q;
        end else begin : g_comb
            assign c  = sum;
            assign co = carry;
        end
    endgenerate

    // Saturate rather than wrap so long characterisation runs stay meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (carry && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bit_adder_unit.sv
// Directed and random checks for bit_adder_unit in combinational, registered
// and narrow-counter configurations sharing one clock and stimulus.
module tb_bit_adder_unit;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       c0;
    logic       co0;
    logic [7:0] cnt0;
    logic       c1;
    logic       co1;
    logic [7:0] cnt1;
    logic       c2;
    logic       co2;
    logic [1:0] cnt2;

    int tests;
    int fails;

    bit_adder_unit #(.REG_OUT(1'b0), .CNT_W(8)) u_comb (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .c(c0), .co(co0), .carry_cnt(cnt0)
    );

    bit_adder_unit #(.REG_OUT(1'b1), .CNT_W(8)) u_reg (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .c(c1), .co(co1), .carry_cnt(cnt1)
    );

    bit_adder_unit #(.REG_OUT(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .c(c2), .co(co2), .carry_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        @(negedge clk);
        tests++;
        if (cnt0 !== 8'd0) begin
            fails++;
            $display("FAIL reset_cnt0 got %0d want 0", cnt0);
        end
        tests++;
        if (cnt2 !== 2'd0) begin
            fails++;
            $display("FAIL reset_cnt2 got %0d want 0", cnt2);
        end
        tests++;
        if ({c1, co1} !== 2'b00) begin
            fails++;
            $display("FAIL reset_reg_out got %b want 00", {c1, co1});
        end
        tests++;
        if ({c0, co0} !== 2'b00) begin
            fails++;
            $display("FAIL reset_comb_out got %b want 00", {c0, co0});
        end
    endtask

    task automatic test_exhaustive();
        logic [1:0] vin [4];
        logic [1:0] vexp [4];
        vin  = '{2'b00, 2'b10, 2'b01, 2'b11};
        vexp = '{2'b00, 2'b10, 2'b10, 2'b01};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a, b} = vin[i];
            #1;
            tests++;
            if ({c0, co0} !== vexp[i]) begin
                fails++;
                $display("FAIL exh_imm[%0d] got %b want %b", i, {c0, co0}, vexp[i]);
            end
            @(negedge clk);
            @(negedge clk);
            tests++;
            if ({c0, co0} !== vexp[i]) begin
                fails++;
                $display("FAIL exh_hold[%0d] got %b want %b", i, {c0, co0}, vexp[i]);
            end
        end
    endtask

    task automatic test_comb_reset_indep();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b0;
        #1;
        tests++;
        if ({c0, co0} !== 2'b10) begin
            fails++;
            $display("FAIL comb_rst_indep got %b want 10", {c0, co0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic ea;
        logic eb;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ea = 1'($urandom_range(1, 0));
            eb = 1'($urandom_range(1, 0));
            a  = ea;
            b  = eb;
            #1;
            tests++;
            if ((c0 !== (ea ^ eb)) || (co0 !== (ea & eb))) begin
                fails++;
                $display("FAIL random[%0d] a=%b b=%b got c=%b co=%b want c=%b co=%b",
                         i, ea, eb, c0, co0, ea ^ eb, ea & eb);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        @(negedge clk);
        tests++;
        if ({c1, co1} !== 2'b00) begin
            fails++;
            $display("FAIL reg_after_rst got %b want 00", {c1, co1});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({c1, co1} !== 2'b01) begin
            fails++;
            $display("FAIL reg_11 got %b want 01", {c1, co1});
        end
        a = 1'b1;
        b = 1'b0;
        #1;
        tests++;
        if ({c1, co1} !== 2'b01) begin
            fails++;
            $display("FAIL reg_no_early got %b want 01", {c1, co1});
        end
        @(negedge clk);
        tests++;
        if ({c1, co1} !== 2'b10) begin
            fails++;
            $display("FAIL reg_10 got %b want 10", {c1, co1});
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        a   = 1'b1;
        b   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tests++;
            if (cnt0 !== 8'(i)) begin
                fails++;
                $display("FAIL cnt_inc[%0d] got %0d want %0d", i, cnt0, i);
            end
        end
        b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (cnt0 !== 8'd5) begin
                fails++;
                $display("FAIL cnt_hold[%0d] got %0d want 5", i, cnt0);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] sexp [6];
        sexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a   = 1'b1;
        b   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (cnt2 !== sexp[i]) begin
                fails++;
                $display("FAIL sat[%0d] got %0d want %0d", i, cnt2, sexp[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ((cnt0 !== 8'd0) || (cnt2 !== 2'd0) || ({c1, co1} !== 2'b00)) begin
                fails++;
                $display("FAIL rstpri[%0d] got cnt0=%0d cnt2=%0d c1co1=%b want 0 0 00",
                         i, cnt0, cnt2, {c1, co1});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ((cnt0 !== 8'd1) || (cnt2 !== 2'd1) || ({c1, co1} !== 2'b01)) begin
            fails++;
            $display("FAIL rstpri_resume got cnt0=%0d cnt2=%0d c1co1=%b want 1 1 01",
                     cnt0, cnt2, {c1, co1});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        a     = 1'b0;
        b     = 1'b0;
        test_reset();
        test_exhaustive();
        test_comb_reset_indep();
        test_random();
        test_registered();
        test_counter();
        test_saturation();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
